// File: rtl/wwd_display.sv
// Display stage for the TSC CPU: keeps the last four WWD words and scans the selected
// one in hex across a 4-digit multiplexed seven-segment display; mirrors the PC byte on LEDs.
module wwd_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset_cpu,
    input  logic [15:0] output_port,
    input  logic        wwd_valid,
    input  logic        freeze,
    input  logic [1:0]  hist_sel,
    input  logic [7:0]  PC_below8bit,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [7:0]  led,
    output logic [2:0]  hist_count
);
    localparam logic [15:0] LP_C_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] r_h [4];
    logic [2:0]  r_count;
    logic [15:0] r_c;
    logic [1:0]  r_d;
    logic [6:0]  r_seg;
    logic [3:0]  r_an;
    logic [7:0]  r_led;

    logic        w_capture;
    logic        w_sel_valid;
    logic [15:0] w_word;
    logic [3:0]  w_nibble;
    logic [6:0]  w_hex;
    logic [6:0]  w_seg_next;
    logic [3:0]  w_an_next;

    // A frozen display drops strobes outright; nothing is queued for later.
    assign w_capture = wwd_valid & ~freeze;

    always_comb begin
        w_sel_valid = ({1'b0, hist_sel} < r_count);
        w_word      = r_h[hist_sel];
        w_nibble    = w_word[{r_d, 2'b00} +: 4];
        w_an_next   = ~(4'b0001 << r_d);
        w_hex       = 7'h7F;
        case (w_nibble)
            4'h0: w_hex = 7'h40;
            4'h1: w_hex = 7'h79;
            4'h2: w_hex = 7'h24;
            4'h3: w_hex = 7'h30;
            4'h4: w_hex = 7'h19;
            4'h5: w_hex = 7'h12;
            4'h6: w_hex = 7'h02;
            4'h7: w_hex = 7'h78;
            4'h8: w_hex = 7'h00;
            4'h9: w_hex = 7'h10;
            4'hA: w_hex = 7'h08;
            4'hB: w_hex = 7'h03;
            4'hC: w_hex = 7'h46;
            4'hD: w_hex = 7'h21;
            4'hE: w_hex = 7'h06;
            4'hF: w_hex = 7'h0E;
            default: w_hex = 7'h7F;
        endcase
        w_seg_next = w_sel_valid ? w_hex : 7'h3F;
    end

    always_ff @(posedge clk) begin
        if (reset_cpu) begin
            for (int i = 0; i < 4; i++) r_h[i] <= 16'h0000;
            r_count <= 3'd0;
        end else if (w_capture) begin
            r_h[3]  <= r_h[2];
            r_h[2]  <= r_h[1];
            r_h[1]  <= r_h[0];
            r_h[0]  <= output_port;
            r_count <= (r_count == 3'd4) ? 3'd4 : r_count + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_cpu) begin
            r_c <= 16'd0;
            r_d <= 2'd0;
        end else if (r_c == LP_C_LAST) begin
            r_c <= 16'd0;
            r_d <= r_d + 2'd1;
        end else begin
            r_c <= r_c + 16'd1;
        end
    end

    // Segment and anode registers are loaded from the state seen before this edge.
    always_ff @(posedge clk) begin
        if (reset_cpu) begin
            r_seg <= 7'h7F;
            r_an  <= 4'hF;
            r_led <= 8'h00;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
            r_led <= PC_below8bit;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign led        = r_led;
    assign hist_count = r_count;
endmodule

// File: tb/tb_wwd_display.sv
// Directed bench for wwd_display: a queue-based history model checked on every cycle
// plus literal expectations for the key display sequences.
module tb_wwd_display;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        reset_cpu;
  logic [15:0] output_port;
  logic        wwd_valid;
  logic        freeze;
  logic [1:0]  hist_sel;
  logic [7:0]  PC_below8bit;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [7:0]  led;
  logic [2:0]  hist_count;

  wwd_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk          (clk),
    .reset_cpu    (reset_cpu),
    .output_port  (output_port),
    .wwd_valid    (wwd_valid),
    .freeze       (freeze),
    .hist_sel     (hist_sel),
    .PC_below8bit (PC_below8bit),
    .seg          (seg),
    .an           (an),
    .led          (led),
    .hist_count   (hist_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // behavioural model: history as a newest-first queue, scan position from ticks since reset
  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0] m_hist [$];
  int          m_ticks = 0;
  bit          m_ready = 0;
  int          m_dig;
  logic [15:0] m_word;
  logic [3:0]  m_nib;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic [7:0]  e_led;
  int          e_cnt;

  // Inputs change just after posedge, so at negedge they are exactly what the next edge samples.
  always @(negedge clk) begin
    if (m_ready) begin
      check("model_seg", 16'(seg), 16'(e_seg));
      check("model_an", 16'(an), 16'(e_an));
      check("model_led", 16'(led), 16'(e_led));
      check("model_hist_count", 16'(hist_count), 16'(e_cnt));
    end
    if (reset_cpu) begin
      m_hist.delete();
      m_ticks = 0;
      e_seg = 7'h7F;
      e_an  = 4'hF;
      e_led = 8'h00;
    end else begin
      m_dig = (m_ticks / SCAN_DIV) % 4;
      if (int'(hist_sel) < m_hist.size()) begin
        m_word = m_hist[hist_sel];
        m_nib  = 4'(m_word >> (4 * m_dig));
        e_seg  = hex_tab[m_nib];
      end else begin
        e_seg = 7'h3F;
      end
      e_an  = ~(4'b0001 << m_dig);
      e_led = PC_below8bit;
      m_ticks++;
      if (wwd_valid && !freeze) begin
        m_hist.push_front(output_port);
        if (m_hist.size() > 4) void'(m_hist.pop_back());
      end
    end
    e_cnt = m_hist.size();
    m_ready = 1;
  end

  // driver tasks
  logic [7:0] pc_next = 8'h03;

  task automatic tick();
    @(posedge clk);
    #2;
    PC_below8bit = pc_next;
    pc_next = pc_next + 8'h1D;
  endtask

  task automatic capture(input logic [15:0] word);
    output_port = word;
    wwd_valid = 1'b1;
    tick();
    wwd_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset_cpu = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    reset_cpu = 1'b0;
    tick();
  endtask

  // Walks 16 cycles; each digit must show exp_dig[k] when an selects digit k.
  task automatic scan_expect(input string name, input logic [6:0] d0, input logic [6:0] d1,
                             input logic [6:0] d2, input logic [6:0] d3);
    for (int i = 0; i < 16; i++) begin
      tick();
      case (an)
        4'hE: check({name, "_d0"}, 16'(seg), 16'(d0));
        4'hD: check({name, "_d1"}, 16'(seg), 16'(d1));
        4'hB: check({name, "_d2"}, 16'(seg), 16'(d2));
        4'h7: check({name, "_d3"}, 16'(seg), 16'(d3));
        default: check({name, "_an"}, 16'(an), 16'hE);
      endcase
    end
  endtask

  logic [3:0] an_seq [3] = '{4'hE, 4'hD, 4'hB};
  bit found;

  initial begin
    reset_cpu = 1'b1;
    output_port = 16'h0000;
    wwd_valid = 1'b0;
    freeze = 1'b0;
    hist_sel = 2'd0;
    PC_below8bit = 8'h00;

    // reset held two cycles
    tick();
    check("rst_seg", 16'(seg), 16'h7F);
    check("rst_an", 16'(an), 16'hF);
    check("rst_count", 16'(hist_count), 16'h0);
    tick();
    check("rst_seg2", 16'(seg), 16'h7F);
    reset_cpu = 1'b0;
    tick();
    check("post_rst_seg", 16'(seg), 16'h3F);
    for (int i = 0; i < 12; i++) begin
      check("scan_hold_an", 16'(an), 16'(an_seq[i / 4]));
      tick();
    end

    // single capture
    hist_sel = 2'd0;
    capture(16'h12AF);
    check("single_count", 16'(hist_count), 16'h1);
    scan_expect("single", 7'h0E, 7'h08, 7'h24, 7'h79);

    // history fill and saturation
    for (int i = 1; i <= 5; i++) begin
      output_port = 16'(i);
      wwd_valid = 1'b1;
      tick();
    end
    wwd_valid = 1'b0;
    check("fill_count", 16'(hist_count), 16'h4);
    scan_expect("newest", 7'h12, 7'h40, 7'h40, 7'h40);
    hist_sel = 2'd3;
    tick();
    scan_expect("oldest", 7'h24, 7'h40, 7'h40, 7'h40);
    hist_sel = 2'd2;
    tick();
    scan_expect("third", 7'h30, 7'h40, 7'h40, 7'h40);

    // invalid selection
    hist_sel = 2'd0;
    do_reset(1);
    capture(16'h7777);
    hist_sel = 2'd2;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("invalid_dash", 16'(seg), 16'h3F);
      tick();
    end
    hist_sel = 2'd0;
    tick();
    check("restore_word", 16'(seg), 16'h78);

    // freeze drops the strobe but led keeps tracking
    freeze = 1'b1;
    output_port = 16'hBEEF;
    wwd_valid = 1'b1;
    PC_below8bit = 8'h15;
    @(posedge clk);
    #2;
    wwd_valid = 1'b0;
    freeze = 1'b0;
    check("freeze_led", 16'(led), 16'h15);
    check("freeze_count", 16'(hist_count), 16'h1);
    tick();
    check("freeze_word", 16'(seg), 16'h78);

    // reset during digit 2 with three entries, strobe coincident with reset
    capture(16'h1111);
    capture(16'h2222);
    check("mid_count3", 16'(hist_count), 16'h3);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (an == 4'hB) found = 1;
      else tick();
    end
    if (!found) check("wait_digit2", 16'(an), 16'hB);
    reset_cpu = 1'b1;
    wwd_valid = 1'b1;
    output_port = 16'hAAAA;
    freeze = 1'b1;
    tick();
    check("mid_rst_seg", 16'(seg), 16'h7F);
    check("mid_rst_an", 16'(an), 16'hF);
    check("mid_rst_led", 16'(led), 16'h00);
    check("mid_rst_count", 16'(hist_count), 16'h0);
    reset_cpu = 1'b0;
    wwd_valid = 1'b0;
    freeze = 1'b0;
    tick();
    check("mid_post_an", 16'(an), 16'hE);
    check("mid_post_seg", 16'(seg), 16'h3F);
    check("mid_post_count", 16'(hist_count), 16'h0);
    tick();
    tick();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/wwd_display.md
# wwd_display

Downstream display stage for the TSC CPU. It captures each word the CPU emits on `output_port` during a WWD and keeps the last four captured words. It drives a 4-digit multiplexed seven-segment display with the selected word in hex. It also registers `PC_below8bit` onto the LED bank, and is the only consumer of those CPU outputs on the board.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays lit; legal range 2..65535.
- `clk`, input, 1: system clock; all state changes on its rising edge.
- `reset_cpu`, input, 1: synchronous, active-high reset, shared with the CPU.
- `output_port`, input, 16: word presented by the CPU.
- `wwd_valid`, input, 1: one-cycle strobe; high means `output_port` holds a WWD result this cycle.
- `freeze`, input, 1: when high, captures are suppressed and the history is held.
- `hist_sel`, input, 2: entry shown on the display; 0 = newest, 3 = oldest.
- `PC_below8bit`, input, 8: lower PC byte from the CPU.
- `seg`, output, 7: segments {g,f,e,d,c,b,a}, active-low, registered.
- `an`, output, 4: digit enables, active-low, registered; bit 0 is the rightmost digit.
- `led`, output, 8: registered copy of `PC_below8bit`.
- `hist_count`, output, 3: number of valid history entries, 0..4.

## Operation
- **History**
  - Four 16-bit registers h0..h3, where h0 is the newest.
  - On a capture (`wwd_valid`=1 and `freeze`=0), the registers shift on the same edge: h3<=h2, h2<=h1, h1<=h0, h0<=`output_port`.
  - On each capture, `hist_count` increments and saturates at 4.
  - With `freeze`=1, `wwd_valid` is ignored entirely: no shift and no count change. The captured word is lost, not queued.
- **Selection**
  - The display word is h[`hist_sel`].
  - The entry is valid iff `hist_sel` < `hist_count`.
  - An invalid entry shows a dash on all four digits.
- **Scan**
  - Digit index d (2 bits) and divider counter c (16 bits, counts 0..SCAN_DIV-1).
  - When c = SCAN_DIV-1, c wraps to 0 and d increments, wrapping 3 to 0.
  - `an` = ~(4'b0001 << d).
  - Digit d displays nibble word[4d+3:4d].
- **Encoding (active-low gfedcba)**

  | Char | Code | Char | Code |
  |---|---|---|---|
  | 0 | 0x40 | 8 | 0x00 |
  | 1 | 0x79 | 9 | 0x10 |
  | 2 | 0x24 | A | 0x08 |
  | 3 | 0x30 | b | 0x03 |
  | 4 | 0x19 | C | 0x46 |
  | 5 | 0x12 | d | 0x21 |
  | 6 | 0x02 | E | 0x06 |
  | 7 | 0x78 | F | 0x0E |

  - Dash is 0x3F.
  - No leading-zero blanking.
- **LED**: `led` <= `PC_below8bit` every cycle, including while frozen.

## Timing
- **Reset** (takes priority over all inputs on that edge):
  - h0..h3 = 0, `hist_count` = 0, c = 0, d = 0.
  - `seg` = 7'h7F (all off), `an` = 4'hF, `led` = 0.
- **First cycle after reset**: `seg`/`an` are computed from the reset state, so the display shows digit 0 with a dash (`hist_count`=0).
- **Capture latency**:
  - Strobe sampled at edge N; h0 and `hist_count` update at edge N.
  - `seg` reflects the new word at edge N+1, because `seg`/`an` are registered from the current state.
- **Other input latency**:
  - `hist_sel` changes take effect on `seg` one edge later.
  - `led` lags `PC_below8bit` by one cycle.
- **Back-to-back strobes**: every cycle captures; four consecutive strobes fill the history.
- **Saturation**: a 5th or later capture discards old h3; `hist_count` stays at 4.
- **Reset mid-scan or while frozen**: all state is cleared as listed above; `freeze` has no effect on reset.
- **Scan wrap**: `an` sequence is E, D, B, 7, E, …, with each value held exactly SCAN_DIV cycles.

## Test plan
All scenarios use SCAN_DIV=4.

- **Reset**: hold `reset_cpu` 2 cycles, then release.
  - During reset: `seg`=0x7F, `an`=0xF, `hist_count`=0.
  - First cycle after release: `an`=0xE, `seg`=0x3F.
  - Each subsequent `an` value holds for 4 cycles.
- **Single capture**: `output_port`=0x12AF with a `wwd_valid` pulse, `hist_sel`=0.
  - `hist_count`=1.
  - Over one scan period, `seg` shows F(0x0E), A(0x08), 2(0x24), 1(0x79) on `an`=E, D, B, 7 respectively.
- **History fill and saturation**: capture 0x0001, 0x0002, 0x0003, 0x0004, 0x0005 on back-to-back cycles.
  - `hist_count`=4.
  - `hist_sel`=0 shows 0005; `hist_sel`=3 shows 0002.
  - 0001 is lost.
- **Invalid selection**: after one capture, set `hist_sel`=2.
  - All digits show 0x3F.
  - Switching back to `hist_sel`=0 restores the word after 1 cycle.
- **Freeze**: `freeze`=1 with a `wwd_valid` pulse on 0xBEEF.
  - History and `hist_count` unchanged.
  - `led` still tracks `PC_below8bit`, e.g. 0x15 appears on `led` one cycle later.
- **Mid-operation reset**: assert `reset_cpu` during digit 2 with `hist_count`=3.
  - Next edge: all state is at reset values.
  - A `wwd_valid` pulse coincident with reset is not captured.
